unary_bs_counter: RTL



---
 rtl/unary_pkg.sv | 20 ++
 rtl/popcount_chunk.sv | 26 ++
 rtl/unary_bs_counter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/unary_pkg.sv
// Shared definitions for the unary/stochastic computing blocks
// (bitstream generator, bitstream counter and future unary operators).
package unary_pkg;

    localparam int BS_LEN_DEF = 2048;

    typedef enum logic [1:0] {
        MODE_PASS = 2'd0,
        MODE_AND  = 2'd1,
        MODE_XNOR = 2'd2,
        MODE_OR   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/popcount_chunk.sv
// Combinational popcount of CHUNK bits, built as a balanced pairwise adder tree.
module popcount_chunk #(
    parameter int CHUNK = 64,
    parameter int PC_W  = $clog2(CHUNK + 1)
) (
    input  logic [CHUNK-1:0] data,
    output logic [PC_W-1:0]  cnt
);

    always_comb begin
        logic [PC_W-1:0] s [CHUNK];
        // NOTE: blocking assignments here are intentional; each tree level
        // overwrites the lower half of s in place, and entry i only reads
        // entries 2i and 2i+1, which this level has not yet rewritten.
        for (int i = 0; i < CHUNK; i++) begin
            s[i] = PC_W'(data[i]);
        end
        for (int l = 0; l < $clog2(CHUNK); l++) begin
            for (int i = 0; i < (CHUNK >> (l + 1)); i++) begin
                s[i] = s[2*i] + s[2*i+1];
            end
        end
        cnt = s[0];
    end

endmodule

// File: rtl/unary_bs_counter.sv
// Decodes one or two unary bitstreams back to binary: applies a per-bit operator
// and popcounts the result CHUNK bits per cycle, LSB chunk first.
module unary_bs_counter
    import unary_pkg::*;
#(
    parameter int BS_LEN = BS_LEN_DEF,
    parameter int CHUNK  = 64,
    parameter int CNT_W  = $clog2(BS_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BS_LEN-1:0] bs_a,
    input  logic [BS_LEN-1:0] bs_b,
    input  logic [1:0]        mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  count
);

    localparam int NCHUNK = BS_LEN / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int PC_W   = $clog2(CHUNK + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCHUNK - 1);

    state_e            state;
    state_e            state_next;
    logic [BS_LEN-1:0] a_q;
    logic [BS_LEN-1:0] b_q;
    mode_e             mode_q;
    logic [CNT_W-1:0]  acc;
    logic [CNT_W-1:0]  acc_sum;
    logic [CNT_W-1:0]  count_q;
    logic [IDX_W-1:0]  idx;
    logic [CHUNK-1:0]  a_chunk;
    logic [CHUNK-1:0]  b_chunk;
    logic [CHUNK-1:0]  op_chunk;
    logic [PC_W-1:0]   chunk_cnt;
    logic              accept;
    logic              last;

    assign accept = (state == ST_IDLE) && in_valid;
    assign last   = (idx == IDX_LAST);
    assign count  = count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // through the case statement can leave a latch behind.
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = ST_ACC;
            end
            ST_ACC: begin
                if (last) state_next = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // NOTE: the wide bitstream and mode registers have no reset; they are only
    // ever read after a handshake has loaded them, so a reset would buy nothing.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            a_q    <= bs_a;
            b_q    <= bs_b;
            mode_q <= mode_e'(mode);
        end
    end

    assign a_chunk = a_q[idx*CHUNK +: CHUNK];
    assign b_chunk = b_q[idx*CHUNK +: CHUNK];

    always_comb begin
        op_chunk = a_chunk;
        unique case (mode_q)
            MODE_PASS: op_chunk = a_chunk;
            MODE_AND:  op_chunk = a_chunk & b_chunk;
            MODE_XNOR: op_chunk = ~(a_chunk ^ b_chunk);
            MODE_OR:   op_chunk = a_chunk | b_chunk;
            default:   op_chunk = a_chunk;
        endcase
    end

    popcount_chunk #(
        .CHUNK (CHUNK),
        .PC_W  (PC_W)
    ) u_popcount (
        .data (op_chunk),
        .cnt  (chunk_cnt)
    );

    // Accumulator cannot overflow: the largest possible total is BS_LEN itself.
    assign acc_sum = acc + CNT_W'(chunk_cnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            idx     <= '0;
            count_q <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        acc <= '0;
                        idx <= '0;
                    end
                end
                ST_ACC: begin
                    acc <= acc_sum;
                    idx <= idx + 1'b1;
                    if (last) count_q <= acc_sum;
                end
                default: ;
            endcase
        end
    end

endmodule
